// File: rtl/loopyV_data_types.sv
// ==========================================================================
// loopyV_data_types : shared types for the rv32imc memory arbiter
// Revision 1.0
// ==========================================================================
`default_nettype none

package loopyV_data_types;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IM   = 2'd1,
        OWNER_DM   = 2'd2
    } rsp_owner_t;

    localparam int STARVE_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ==========================================================================
// mem_port_arbiter : fetch/data arbiter for one single-port sync memory
// Revision 1.0
// ==========================================================================
`default_nettype none

module mem_port_arbiter
    import loopyV_data_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstN,

    input  logic        imReq,
    input  logic [31:0] imAddr,
    output logic        imGnt,
    output logic        imRvalid,
    output logic [31:0] imRdata,

    input  logic        dmReadEn,
    input  logic        dmWriteEn,
    input  logic [31:0] dmAddr,
    input  logic [31:0] dmWriteData,
    input  logic [3:0]  dmWriteMask,
    output logic        dmGnt,
    output logic        dmRvalid,
    output logic [31:0] dmReadData,

    input  logic        memReady,
    output logic [31:0] memAddr,
    output logic        memReadEn,
    output logic        memWriteEn,
    output logic [31:0] memWriteData,
    output logic [3:0]  memWriteMask,
    input  logic [31:0] memReadData
);

    localparam logic [STARVE_CNT_W-1:0] C_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    rsp_owner_t              rsp_owner_q, rsp_owner_d;

    logic w_dm_req;
    logic w_force_im;
    logic w_gnt_dm;
    logic w_gnt_im;

    // Grants are gated by rstN so nothing reaches the memory while reset is held.
    assign w_dm_req   = dmReadEn | dmWriteEn;
    assign w_force_im = imReq && (starve_cnt_q == C_LIMIT);
    assign w_gnt_dm   = rstN && memReady && w_dm_req && !w_force_im;
    assign w_gnt_im   = rstN && memReady && imReq && !w_gnt_dm;

    assign imGnt = w_gnt_im;
    assign dmGnt = w_gnt_dm;

    always_comb begin
        memAddr      = 32'd0;
        memReadEn    = 1'b0;
        memWriteEn   = 1'b0;
        memWriteData = 32'd0;
        memWriteMask = 4'd0;
        if (w_gnt_dm) begin
            memAddr      = dmAddr;
            memReadEn    = !dmWriteEn;
            memWriteEn   = dmWriteEn;
            memWriteData = dmWriteData;
            memWriteMask = dmWriteMask;
        end else if (w_gnt_im) begin
            memAddr   = imAddr;
            memReadEn = 1'b1;
        end
    end

    always_comb begin
        imRvalid   = (rsp_owner_q == OWNER_IM);
        dmRvalid   = (rsp_owner_q == OWNER_DM);
        imRdata    = imRvalid ? memReadData : 32'd0;
        dmReadData = dmRvalid ? memReadData : 32'd0;
    end

    // A stalled memory freezes the counter even if fetch withdraws its request.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (memReady) begin
            if (w_gnt_dm && imReq) begin
                starve_cnt_d = (starve_cnt_q == C_LIMIT) ? starve_cnt_q
                                                         : starve_cnt_q + 1'b1;
            end else if (w_gnt_im || !imReq) begin
                starve_cnt_d = '0;
            end
        end
    end

    always_comb begin
        rsp_owner_d = OWNER_NONE;
        if (w_gnt_im) begin
            rsp_owner_d = OWNER_IM;
        end else if (w_gnt_dm && !dmWriteEn) begin
            rsp_owner_d = OWNER_DM;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            starve_cnt_q <= '0;
            rsp_owner_q  <= OWNER_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_owner_q  <= rsp_owner_d;
        end
    end

endmodule

`default_nettype wire
